mod_up_down_counter: RTL and testbench

MOD_UP_DOWN_COUNTER -- requirements
Module: mod_up_down_counter

---
 rtl/mod_up_down_counter_pkg.sv | 22 ++
 rtl/mod_up_down_counter_if.sv | 23 ++
 rtl/counter_step_calc.sv | 75 +++++++
 rtl/mod_up_down_counter.sv | 81 ++++++++
 tb/tb_mod_up_down_counter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mod_up_down_counter_pkg.sv
// rtl/mod_up_down_counter_pkg.sv - shared constants and step-path encoding for the bounded up/down counter
package mod_up_down_counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Which way an enabled step resolved; everything except HOLD/STEP is a bound event.
  typedef enum logic [2:0] {
    PATH_HOLD    = 3'd0,
    PATH_STEP    = 3'd1,
    PATH_WRAP    = 3'd2,
    PATH_CLAMP   = 3'd3,
    PATH_RECOVER = 3'd4
  } path_e;

  function automatic logic is_bound_event(input path_e p);
    return (p == PATH_WRAP) || (p == PATH_CLAMP) || (p == PATH_RECOVER);
  endfunction

endpackage

// File: rtl/mod_up_down_counter_if.sv
// rtl/mod_up_down_counter_if.sv - control bus carrying step, bound and load settings into the counter
interface mod_up_down_counter_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             dir;
  logic             load;
  logic             sat;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] step;

  modport master (
    output en, dir, load, sat, load_val, lo, hi, step
  );

  modport slave (
    input en, dir, load, sat, load_val, lo, hi, step
  );

endinterface

// File: rtl/counter_step_calc.sv
// rtl/counter_step_calc.sv - combinational next-count, bound-event and load-clamp computation
module counter_step_calc
  import mod_up_down_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  mod_up_down_counter_if.slave  ctl,
  input  logic [WIDTH-1:0]      count_i,
  output logic [WIDTH-1:0]      next_o,
  output path_e                 path_o,
  output logic [WIDTH-1:0]      load_clamped_o,
  output logic                  cfg_err_o
);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] lo_x;
  logic [WIDTH:0] hi_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] floor_x;

  // One extra bit so count+step and lo+step never lose their carry.
  assign cnt_x   = {1'b0, count_i};
  assign lo_x    = {1'b0, ctl.lo};
  assign hi_x    = {1'b0, ctl.hi};
  assign step_x  = {1'b0, ctl.step};
  assign sum_x   = cnt_x + step_x;
  assign floor_x = lo_x + step_x;

  assign cfg_err_o = (ctl.lo > ctl.hi);

  always_comb begin
    next_o = count_i;
    path_o = PATH_HOLD;
    if (ctl.step == '0) begin
      next_o = count_i;
      path_o = PATH_HOLD;
    end else if ((cnt_x < lo_x) || (cnt_x > hi_x)) begin
      next_o = ctl.lo;
      path_o = PATH_RECOVER;
    end else if (ctl.dir == DIR_UP) begin
      if (sum_x <= hi_x) begin
        next_o = sum_x[WIDTH-1:0];
        path_o = PATH_STEP;
      end else if (ctl.sat == MODE_SAT) begin
        next_o = ctl.hi;
        path_o = PATH_CLAMP;
      end else begin
        next_o = ctl.lo;
        path_o = PATH_WRAP;
      end
    end else begin
      if (cnt_x >= floor_x) begin
        next_o = count_i - ctl.step;
        path_o = PATH_STEP;
      end else if (ctl.sat == MODE_SAT) begin
        next_o = ctl.lo;
        path_o = PATH_CLAMP;
      end else begin
        next_o = ctl.hi;
        path_o = PATH_WRAP;
      end
    end
  end

  always_comb begin
    load_clamped_o = ctl.load_val;
    if (ctl.load_val < ctl.lo) begin
      load_clamped_o = ctl.lo;
    end else if (ctl.load_val > ctl.hi) begin
      load_clamped_o = ctl.hi;
    end
  end

endmodule

// File: rtl/mod_up_down_counter.sv
// rtl/mod_up_down_counter.sv - bounded up/down counter with wrap or saturate mode and clamped parallel load
module mod_up_down_counter
  import mod_up_down_counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             cfg_err
);

  mod_up_down_counter_if #(.WIDTH(WIDTH)) ctl_if ();

  assign ctl_if.en       = en;
  assign ctl_if.dir      = dir;
  assign ctl_if.load     = load;
  assign ctl_if.sat      = sat;
  assign ctl_if.load_val = load_val;
  assign ctl_if.lo       = lo;
  assign ctl_if.hi       = hi;
  assign ctl_if.step     = step;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;
  path_e            step_path;
  logic             cfg_err_w;

  counter_step_calc #(.WIDTH(WIDTH)) u_step_calc (
    .ctl            (ctl_if.slave),
    .count_i        (count_q),
    .next_o         (next_count),
    .path_o         (step_path),
    .load_clamped_o (load_clamped),
    .cfg_err_o      (cfg_err_w)
  );

  // A bad bound configuration freezes the counter; load beats an enabled step.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (!cfg_err_w) begin
      if (load) begin
        count_d = load_clamped;
      end else if (en) begin
        count_d = next_count;
        ovf_d   = is_bound_event(step_path);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count   = count_q;
  assign ovf     = ovf_q;
  assign cfg_err = cfg_err_w;

  reset_clears: assert property (@(posedge clk) rst |=> (count == RST_VAL) && !ovf);
  cfg_err_quiet: assert property (@(posedge clk) (cfg_err && !rst) |=> !ovf);

endmodule

// File: tb/tb_mod_up_down_counter.sv
// tb/tb_mod_up_down_counter.sv - directed table-driven bench for the bounded up/down counter at WIDTH=4
module tb_mod_up_down_counter;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic       ovf;
  logic       cfg_err;

  int checks;
  int failures;

  mod_up_down_counter_if #(.WIDTH(4)) bus ();

  mod_up_down_counter #(.WIDTH(4), .RST_VAL(4'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .dir      (bus.dir),
    .load     (bus.load),
    .load_val (bus.load_val),
    .lo       (bus.lo),
    .hi       (bus.hi),
    .step     (bus.step),
    .sat      (bus.sat),
    .count    (count),
    .ovf      (ovf),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic       sat;
    logic [3:0] load_val;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] step;
    logic [3:0] exp_count;
    logic       exp_ovf;
    logic       exp_cfg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int r, input int e, input int d, input int ld, input int s,
                              input int lv, input int lo_v, input int hi_v, input int st,
                              input int ec, input int eo, input int ecfg);
    vec_t v;
    v.rst       = 1'(r);
    v.en        = 1'(e);
    v.dir       = 1'(d);
    v.load      = 1'(ld);
    v.sat       = 1'(s);
    v.load_val  = 4'(lv);
    v.lo        = 4'(lo_v);
    v.hi        = 4'(hi_v);
    v.step      = 4'(st);
    v.exp_count = 4'(ec);
    v.exp_ovf   = 1'(eo);
    v.exp_cfg   = 1'(ecfg);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst          = v.rst;
    bus.en       = v.en;
    bus.dir      = v.dir;
    bus.load     = v.load;
    bus.sat      = v.sat;
    bus.load_val = v.load_val;
    bus.lo       = v.lo;
    bus.hi       = v.hi;
    bus.step     = v.step;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            rst en dir ld sat lv lo hi st  count ovf cfg
    vecs.push_back(mk(0, 0, 0, 1, 0,  3, 3, 9, 2,  3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 3, 9, 2,  5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 3, 9, 2,  7, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 3, 9, 2,  9, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 3, 9, 2,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 3, 9, 2,  3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1,  7, 2, 9, 3,  7, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1,  0, 2, 9, 3,  4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1,  0, 2, 9, 3,  2, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1,  0, 2, 9, 3,  2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 2, 9, 3,  5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 2, 9, 3,  8, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 2, 9, 3,  9, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,  0, 2, 9, 3,  2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 12, 2, 9, 3,  9, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1,  4, 2, 9, 3,  4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 2, 9, 3,  7, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 2, 9, 0,  7, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 2, 9, 3,  4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 2, 9, 3,  9, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 2, 6, 1,  2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 15, 15, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 15, 15, 15, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 15, 15, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 1, 15, 15, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1, 15, 14, 15, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0,  7, 1, 15, 14, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 15, 1,  1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 10, 5, 1,  1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0,  3, 10, 5, 1,  1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 15, 1,  2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 10, 5, 1,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 15, 1,  0, 0, 0));

    // Reset for two cycles with counting already requested, then a full wrap of the 4-bit range.
    drive(mk(1, 1, 0, 0, 0, 0, 0, 15, 1, 0, 0, 0));
    repeat (2) begin
      tick();
      check("reset_count", 0, 32'(count), 32'd0);
      check("reset_ovf", 0, 32'(ovf), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("start_count", 0, 32'(count), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("full_range_count", k, 32'(count), 32'(k % 16));
      check("full_range_ovf", k, 32'(ovf), (k == 16) ? 32'd1 : 32'd0);
    end
    bus.en = 1'b0;
    tick();
    check("idle_count", 0, 32'(count), 32'd0);
    check("idle_ovf", 0, 32'(ovf), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      check("vec_count", i, 32'(count), 32'(vecs[i].exp_count));
      check("vec_ovf", i, 32'(ovf), 32'(vecs[i].exp_ovf));
      check("vec_cfg_err", i, 32'(cfg_err), 32'(vecs[i].exp_cfg));
    end

    // Reset lands while a wrapping step is pending; no ovf may escape.
    drive(mk(0, 0, 0, 1, 0, 15, 0, 15, 15, 0, 0, 0));
    tick();
    check("pre_reset_load", 0, 32'(count), 32'd15);
    drive(mk(1, 1, 0, 0, 0, 0, 0, 15, 15, 0, 0, 0));
    tick();
    check("midstep_reset_count", 0, 32'(count), 32'd0);
    check("midstep_reset_ovf", 0, 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();
    check("resume_count", 0, 32'(count), 32'd15);
    check("resume_ovf", 0, 32'(ovf), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
